// File: rtl/ysyx_22040237_defs.sv
// Shared opcode encoding, FSM state type and opcode helpers for the multi-cycle EXU.
package ysyx_22040237_defs;

    localparam logic [7:0] OP_ADD    = 8'h00;
    localparam logic [7:0] OP_SUB    = 8'h01;
    localparam logic [7:0] OP_AND    = 8'h02;
    localparam logic [7:0] OP_OR     = 8'h03;
    localparam logic [7:0] OP_XOR    = 8'h04;
    localparam logic [7:0] OP_SLL    = 8'h05;
    localparam logic [7:0] OP_SRL    = 8'h06;
    localparam logic [7:0] OP_SRA    = 8'h07;
    localparam logic [7:0] OP_SLT    = 8'h08;
    localparam logic [7:0] OP_SLTU   = 8'h09;
    localparam logic [7:0] OP_MUL    = 8'h10;
    localparam logic [7:0] OP_MULH   = 8'h11;
    localparam logic [7:0] OP_MULHSU = 8'h12;
    localparam logic [7:0] OP_MULHU  = 8'h13;
    localparam logic [7:0] OP_DIV    = 8'h14;
    localparam logic [7:0] OP_DIVU   = 8'h15;
    localparam logic [7:0] OP_REM    = 8'h16;
    localparam logic [7:0] OP_REMU   = 8'h17;

    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

    function automatic logic is_md(input logic [7:0] op);
        return (op >= OP_MUL) && (op <= OP_REMU);
    endfunction

endpackage

// File: rtl/ysyx_22040237_mdu_iter.sv
// Iterative multiply (shift-add) / divide (restoring) engine working on operand magnitudes;
// the top FSM loads it on start, steps it once per cycle and samples o_result in FIX.
module ysyx_22040237_mdu_iter
    import ysyx_22040237_defs::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic            i_step,
    input  logic [7:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);
    localparam int CW = $clog2(XLEN);

    logic [7:0]        r_op;
    logic [2*XLEN-1:0] r_prod;
    logic [XLEN-1:0]   r_b;
    logic [XLEN-1:0]   r_origA;
    logic              r_negQ;
    logic              r_negR;
    logic              r_divZero;
    logic [CW-1:0]     r_cnt;

    logic              w_aNeg;
    logic              w_bNeg;
    logic [XLEN-1:0]   w_absA;
    logic [XLEN-1:0]   w_absB;
    logic              w_isMul;
    logic [XLEN:0]     w_mulSum;
    logic [XLEN:0]     w_divShift;
    logic [XLEN:0]     w_divSub;
    logic [2*XLEN-1:0] w_stepProd;
    logic [2*XLEN-1:0] w_prodFix;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;

    assign w_aNeg = i_a[XLEN-1] && (i_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    assign w_bNeg = i_b[XLEN-1] && (i_op inside {OP_MULH, OP_DIV, OP_REM});
    assign w_absA = w_aNeg ? -i_a : i_a;
    assign w_absB = w_bNeg ? -i_b : i_b;
    assign w_isMul = r_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};

    // Multiply consumes the low half as the multiplier; divide shifts the dividend out of it
    // and the quotient bits in behind.
    assign w_mulSum   = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_b} : '0);
    assign w_divShift = {r_prod[2*XLEN-1:XLEN], r_prod[XLEN-1]};
    assign w_divSub   = w_divShift - {1'b0, r_b};
    assign w_stepProd = w_isMul ? {w_mulSum, r_prod[XLEN-1:1]} :
                        w_divSub[XLEN] ? {w_divShift[XLEN-1:0], r_prod[XLEN-2:0], 1'b0} :
                                         {w_divSub[XLEN-1:0], r_prod[XLEN-2:0], 1'b1};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op      <= '0;
            r_prod    <= '0;
            r_b       <= '0;
            r_origA   <= '0;
            r_negQ    <= 1'b0;
            r_negR    <= 1'b0;
            r_divZero <= 1'b0;
            r_cnt     <= '0;
        end else if (i_start) begin
            r_op      <= i_op;
            r_prod    <= {{XLEN{1'b0}}, w_absA};
            r_b       <= w_absB;
            r_origA   <= i_a;
            r_negQ    <= w_aNeg ^ w_bNeg;
            r_negR    <= w_aNeg;
            r_divZero <= (i_b == '0);
            r_cnt     <= CW'(XLEN - 1);
        end else if (i_step) begin
            r_prod    <= w_stepProd;
            r_cnt     <= r_cnt - 1'b1;
        end
    end

    assign o_done    = (r_cnt == '0);
    assign w_prodFix = r_negQ ? -r_prod : r_prod;
    assign w_quo     = r_prod[XLEN-1:0];
    assign w_rem     = r_prod[2*XLEN-1:XLEN];

    // Signed overflow falls out of the magnitude divide; only divide-by-zero needs overriding.
    always_comb begin
        o_result = '0;
        case (r_op)
            OP_MUL:                        o_result = w_prodFix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  o_result = w_prodFix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               o_result = r_divZero ? '1 : (r_negQ ? -w_quo : w_quo);
            OP_REM, OP_REMU:               o_result = r_divZero ? r_origA : (r_negR ? -w_rem : w_rem);
            default:                       o_result = '0;
        endcase
    end

endmodule

// File: rtl/ysyx_22040237_exu_mc.sv
// Multi-cycle execute unit: single-cycle ALU ops plus an iterative MUL/DIV path,
// valid/ready on both sides, flush, and registered halt/abort beside the result.
module ysyx_22040237_exu_mc
    import ysyx_22040237_defs::*;
#(
    parameter int XLEN   = 64,
    parameter int OP_W   = 8,
    parameter int HAS_MD = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [OP_W-1:0] inst_opcode,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic [XLEN-1:0] op1_jump,
    input  logic [XLEN-1:0] op2_jump,
    input  logic            inst_ebreak,
    input  logic            invalid_inst,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] rd_data,
    output logic [XLEN-1:0] pc_jump_addr,
    output logic            out_halt,
    output logic            out_abort
);
    localparam int SHW = $clog2(XLEN);

    state_t          r_state;
    state_t          w_nextState;
    logic [XLEN-1:0] r_outPc;
    logic [XLEN-1:0] r_rdData;
    logic [XLEN-1:0] r_jump;
    logic            r_halt;
    logic            r_abort;

    logic [7:0]      w_op8;
    logic [SHW-1:0]  w_shamt;
    logic [XLEN-1:0] w_aluResult;
    logic            w_aluValid;
    logic            w_unknown;
    logic            w_isMd;
    logic            w_accept;
    logic            w_mdLast;
    logic [XLEN-1:0] w_mdResult;

    assign w_op8   = 8'(inst_opcode);
    assign w_shamt = op2[SHW-1:0];

    always_comb begin
        w_aluValid  = 1'b1;
        w_aluResult = '0;
        case (w_op8)
            OP_ADD:  w_aluResult = op1 + op2;
            OP_SUB:  w_aluResult = op1 - op2;
            OP_AND:  w_aluResult = op1 & op2;
            OP_OR:   w_aluResult = op1 | op2;
            OP_XOR:  w_aluResult = op1 ^ op2;
            OP_SLL:  w_aluResult = op1 << w_shamt;
            OP_SRL:  w_aluResult = op1 >> w_shamt;
            OP_SRA:  w_aluResult = $signed(op1) >>> w_shamt;
            OP_SLT:  w_aluResult = {{(XLEN-1){1'b0}}, $signed(op1) < $signed(op2)};
            OP_SLTU: w_aluResult = {{(XLEN-1){1'b0}}, op1 < op2};
            default: w_aluValid  = 1'b0;
        endcase
    end

    // Without the MD engine its opcodes count as unknown and abort like any other.
    assign w_unknown = !w_aluValid && !((HAS_MD != 0) && is_md(w_op8));
    assign w_isMd    = (HAS_MD != 0) && is_md(w_op8) && !inst_ebreak && !invalid_inst;
    assign in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
    assign w_accept  = in_valid && in_ready && !flush;

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: if (w_accept) w_nextState = w_isMd ? PREP : DONE;
            PREP: w_nextState = ITER;
            ITER: if (w_mdLast) w_nextState = FIX;
            FIX:  w_nextState = DONE;
            DONE: if (out_ready) w_nextState = w_accept ? (w_isMd ? PREP : DONE) : IDLE;
            default: w_nextState = IDLE;
        endcase
        if (flush) w_nextState = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_outPc  <= '0;
            r_rdData <= '0;
            r_jump   <= '0;
            r_halt   <= 1'b0;
            r_abort  <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (w_accept) begin
                r_outPc  <= in_pc;
                r_halt   <= inst_ebreak;
                r_abort  <= !inst_ebreak && (invalid_inst || w_unknown);
                r_jump   <= inst_ebreak ? '0 : op1_jump + op2_jump;
                r_rdData <= (inst_ebreak || invalid_inst || !w_aluValid) ? '0 : w_aluResult;
            end else if (r_state == FIX) begin
                r_rdData <= w_mdResult;
            end
        end
    end

    generate
        if (HAS_MD != 0) begin : g_mdu
            ysyx_22040237_mdu_iter #(.XLEN(XLEN)) u_mdu (
                .clk      (clk),
                .rst      (rst),
                .i_start  (w_accept && w_isMd),
                .i_step   ((r_state == PREP) || (r_state == ITER)),
                .i_op     (w_op8),
                .i_a      (op1),
                .i_b      (op2),
                .o_done   (w_mdLast),
                .o_result (w_mdResult)
            );
        end else begin : g_noMdu
            assign w_mdLast   = 1'b1;
            assign w_mdResult = '0;
        end
    endgenerate

    assign out_valid    = (r_state == DONE);
    assign out_pc       = r_outPc;
    assign rd_data      = r_rdData;
    assign pc_jump_addr = r_jump;
    assign out_halt     = r_halt && out_valid;
    assign out_abort    = r_abort && out_valid;

endmodule
